w21_wgt_loader: RTL and testbench
=================================

// Module: w21_wgt_loader
// PURPOSE
//  Write-side counterpart of the w21 per-column weight ROMs: a loadable 300 x 21-bit signed weight store.
//  Weights arrive over a valid/ready stream and are written sequentially into on-chip RAM.
//  Once loading completes, the layer-21 datapath reads the store by column address, with registered output.
//  Lets weights be reloaded at run time instead of being synthesised as constant case tables.
// PARAMETERS
//  DATA_W   21   weight width, two's complement
//  ADDR_W   9    read/write address width
//  DEPTH    300  entries per column (valid addresses 0..299)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous reset, active-high
//  load_start   in   1       one-cycle pulse: begin (re)load at address 0
//  wr_valid     in   1       stream word valid
//  wr_data      in   DATA_W  stream weight
//  wr_ready     out  1       store accepts wr_data this cycle
//  load_done    out  1       level: all DEPTH words written since last load_start
//  rd_en        in   1       read request
//  adrs_clm     in   ADDR_W  read address
//  out          out  DATA_W  registered read data
//  out_valid    out  1       out updated this cycle (1-cycle pulse per read)
//  addr_err     out  1       1-cycle pulse: read address >= DEPTH
//  checksum     out  32      running sum (CHECKSUM_EN builds only)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, wr_ptr=0; wr_ready, load_done, out_valid, addr_err = 0; out=0.
//    RAM contents are not cleared.
//  - FSM states: IDLE, LOAD, READY.
//    IDLE  -load_start->  LOAD
//    LOAD  -last word accepted->  READY
//    READY -load_start->  LOAD
//  - Entering LOAD: wr_ptr=0, load_done=0.
//  - LOAD: wr_ready=1. Handshake: transfer when wr_valid & wr_ready.
//    Each transfer writes RAM[wr_ptr]=wr_data, then wr_ptr++.
//    wr_valid gaps are allowed; no transfer occurs during a gap.
//  - Transfer at wr_ptr==DEPTH-1: wr_ptr wraps to 0 and state=READY on the next cycle.
//    load_done=1 and wr_ready=0 are registered, i.e. they change on the cycle after the last transfer.
//  - load_start during LOAD restarts at wr_ptr=0. A same-cycle transfer is discarded (not written).
//  - wr_ready=0 in IDLE and READY. wr_valid there is ignored.
//  - Read, READY only:
//    * rd_en & adrs_clm<DEPTH -> next cycle out=RAM[adrs_clm], out_valid=1. Latency 1; one read per cycle.
//    * rd_en & adrs_clm>=DEPTH -> next cycle out=0, out_valid=1, addr_err=1.
//  - rd_en outside READY: out_valid=0, out holds its value. Read-during-load is not supported.
//  - load_start and rd_en in the same cycle in READY: load_start wins, the read is dropped (out_valid=0).
//  - Reset mid-load: back to IDLE with load_done=0; partial RAM contents are undefined to consumers.
//  - Arithmetic: wr_ptr is ADDR_W bits, compared against DEPTH-1. No arithmetic on data.
// CONFIGURATION
//  - CHECKSUM_EN defined:
//    * checksum is a 32-bit register, cleared on rst and on load_start.
//    * Each accepted transfer adds sign-extended wr_data, modulo 2^32.
//    * Final value is stable while load_done=1.
//  - CHECKSUM_EN undefined: checksum port absent, no adder logic.
// STRUCTURE
//  - Package w21_pkg:
//    * W21_DATA_W=21, W21_ADDR_W=9, W21_DEPTH=300
//    * typedef logic signed [20:0] w21_wgt_t
//    * enum {IDLE,LOAD,READY} w21_ld_state_t
//  - Sub-module w21_wgt_ram: single-clock simple dual-port RAM
//    (1 sync write port, 1 registered read port), DEPTH x DATA_W.
//  - Top holds the FSM, wr_ptr, read gating, addr_err and the optional checksum.
// TESTING
//  1. Reset, load_start, stream word i = i-150 (sign-extended) for i=0..299 with wr_valid always 1
//     -> wr_ready high 300 cycles; load_done=1 one cycle after last transfer;
//     read 0 -> out=21'h1FFF6A; read 299 -> out=149; each read valid 1 cycle after rd_en.
//  2. Backpressure: wr_valid toggled every other cycle during the load
//     -> exactly 300 transfers, same RAM contents as scenario 1, load_done only after the 300th.
//  3. Out-of-range read: rd_en with adrs_clm=300 and with 511
//     -> out=0, out_valid=1, addr_err=1 for one cycle each.
//  4. rst asserted after 150 transfers
//     -> next cycle wr_ready=0, load_done=0, state IDLE;
//     rd_en gives out_valid=0 until a fresh full load completes.
//  5. In READY, load_start and rd_en in the same cycle
//     -> no out_valid; load_done drops; wr_ready=1 next cycle.
//     load_start mid-load at wr_ptr=100 -> the following transfer writes address 0.
//  6. CHECKSUM_EN: scenario 1 stream -> checksum=32'hFFFFFF6A (sum -150).
//     Reload of all-ones words (-1) -> checksum=32'hFFFFFED4 (-300).

Source files
------------

// File: rtl/w21_pkg.sv
// Shared types and sizes for the layer-21 weight store.
// Widths, depth, the signed weight type and the loader FSM state encoding.
package w21_pkg;
  localparam int W21_DATA_W = 21;
  localparam int W21_ADDR_W = 9;
  localparam int W21_DEPTH  = 300;

  typedef logic signed [20:0] w21_wgt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } w21_ld_state_t;
endpackage

// File: rtl/w21_wgt_ram.sv
// Simple dual-port RAM used as the weight store.
// There is a single clock, one synchronous write port and one read port
// whose data output is registered.
// Ports:
//   clk            clock
//   we/waddr/wdata write port
//   re/raddr       read enable and address; rdata updates only when re=1
//   rdata          registered read data, not reset
module w21_wgt_ram
  import w21_pkg::*;
#(
  parameter int DATA_W = W21_DATA_W,
  parameter int ADDR_W = W21_ADDR_W,
  parameter int DEPTH  = W21_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // The caller only presents addresses below DEPTH on both ports.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/w21_wgt_loader.sv
// Loadable 300 x 21-bit weight store for layer 21.
// Weights stream in over a valid/ready interface after a load_start pulse.
// Once all DEPTH words have been written, the store can be read by column
// address, with a latency of one cycle.
// Optional feature macro: CHECKSUM_EN adds a running 32-bit sum of the
// accepted weights on the checksum port.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   load_start                pulse to begin a (re)load at address 0
//   wr_valid/wr_data/wr_ready weight stream
//   load_done                 level, high once a full load has completed
//   rd_en/adrs_clm            read request and address
//   out/out_valid/addr_err    registered read result, valid pulse, range error pulse
//   checksum                  present only in CHECKSUM_EN builds
module w21_wgt_loader
  import w21_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  wr_valid,
  input  logic [W21_DATA_W-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  load_done,
  input  logic                  rd_en,
  input  logic [W21_ADDR_W-1:0] adrs_clm,
  output logic [W21_DATA_W-1:0] out,
  output logic                  out_valid,
  output logic                  addr_err
`ifdef CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);
  localparam logic [W21_ADDR_W-1:0] LAST_ADDR = W21_ADDR_W'(W21_DEPTH - 1);
  localparam logic [W21_ADDR_W-1:0] DEPTH_A   = W21_ADDR_W'(W21_DEPTH);

  w21_ld_state_t         state_q, state_d;
  logic [W21_ADDR_W-1:0] wr_ptr;
  logic                  xfer, last_xfer, rd_go, rd_ok, zero_q;
  logic [W21_DATA_W-1:0] ram_q;

  // A load_start pulse in the same cycle as a transfer discards that word.
  assign xfer      = (state_q == LOAD) && wr_valid && !load_start;
  assign last_xfer = xfer && (wr_ptr == LAST_ADDR);
  // A load_start pulse in the same cycle as a read drops the read.
  assign rd_go     = (state_q == READY) && rd_en && !load_start;
  assign rd_ok     = adrs_clm < DEPTH_A;

  // Both stream flags come from the state register, so they change on the
  // cycle after the last transfer.
  assign wr_ready  = (state_q == LOAD);
  assign load_done = (state_q == READY);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = LOAD;
      LOAD:    if (!load_start && last_xfer) state_d = READY;
      READY:   if (load_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      addr_err  <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      if (load_start)  wr_ptr <= '0;
      else if (xfer)   wr_ptr <= last_xfer ? '0 : wr_ptr + 1'b1;
      out_valid <= rd_go;
      addr_err  <= rd_go && !rd_ok;
      // The RAM read register is neither reset nor written on a bad
      // address. This flag forces out to zero in both cases.
      if (rd_go) zero_q <= !rd_ok;
    end
  end

  w21_wgt_ram #(
    .DATA_W (W21_DATA_W),
    .ADDR_W (W21_ADDR_W),
    .DEPTH  (W21_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (xfer),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (rd_go && rd_ok),
    .raddr (adrs_clm),
    .rdata (ram_q)
  );

  assign out = zero_q ? '0 : ram_q;

`ifdef CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || load_start) checksum <= '0;
    else if (xfer)
      checksum <= checksum + {{(32-W21_DATA_W){wr_data[W21_DATA_W-1]}}, wr_data};
  end
`endif
endmodule

// File: tb/tb_w21_wgt_loader.sv
module tb_w21_wgt_loader;
  logic        clk = 1'b0;
  logic        rst, load_start, wr_valid, rd_en;
  logic [20:0] wr_data;
  logic [8:0]  adrs_clm;
  logic        wr_ready, load_done, out_valid, addr_err;
  logic [20:0] out;
`ifdef CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model of the store:
  // mode 0 = not loaded, 1 = accepting words, 2 = loaded.
  int          m_mode = 0;
  int          m_ptr  = 0;
  logic [20:0] m_mem [300];
  logic [20:0] m_out  = '0;
  logic        m_vld  = 1'b0;
  logic        m_err  = 1'b0;
  logic [31:0] m_chk  = '0;

  w21_wgt_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .load_done  (load_done),
    .rd_en      (rd_en),
    .adrs_clm   (adrs_clm),
    .out        (out),
    .out_valid  (out_valid),
    .addr_err   (addr_err)
`ifdef CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, advances the model, clocks, then compares.
  task automatic cycle(input logic r, input logic ls, input logic wv, input logic [20:0] wd,
                       input logic re, input logic [8:0] ad);
    rst = r; load_start = ls; wr_valid = wv; wr_data = wd; rd_en = re; adrs_clm = ad;
    m_vld = 1'b0; m_err = 1'b0;
    if (r) begin
      m_mode = 0; m_ptr = 0; m_out = '0; m_chk = '0;
    end else if (ls) begin
      m_mode = 1; m_ptr = 0; m_chk = '0;
    end else if (m_mode == 1) begin
      if (wv) begin
        m_mem[m_ptr] = wd;
        m_chk += 32'(signed'(wd));
        m_ptr++;
        if (m_ptr == 300) begin m_ptr = 0; m_mode = 2; end
      end
    end else if (m_mode == 2 && re) begin
      m_vld = 1'b1;
      if (ad < 300) m_out = m_mem[ad];
      else begin m_out = '0; m_err = 1'b1; end
    end
    @(posedge clk); #1;
    chk("wr_ready",  32'(wr_ready),  32'(m_mode == 1));
    chk("load_done", 32'(load_done), 32'(m_mode == 2));
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("addr_err",  32'(addr_err),  32'(m_err));
    chk("out",       32'(out),       32'(m_out));
`ifdef CHECKSUM_EN
    chk("checksum",  checksum,       m_chk);
`endif
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic rd(input logic [8:0] a);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, a);
  endtask

  initial begin
    int hi;
    int n;
    logic [20:0] d;
    rst = 1'b1; load_start = 0; wr_valid = 0; wr_data = '0; rd_en = 0; adrs_clm = '0;

    // Reset state
    cycle(1'b1, 0, 0, '0, 0, '0);
    cycle(1'b1, 0, 0, '0, 0, '0);
    chk("rst_out", 32'(out), 32'd0);
    // In the unloaded state, stream words are ignored and reads produce nothing.
    cycle(1'b0, 0, 1, 21'h5, 1, 9'd3);

    // Scenario 1: ramp load, i-150, with no gaps.
    hi = 0;
    cycle(1'b0, 1, 0, '0, 0, '0);
    if (wr_ready) hi++;
    for (int i = 0; i < 300; i++) begin
      d = 21'(i - 150);
      cycle(1'b0, 0, 1, d, 0, '0);
      if (wr_ready) hi++;
    end
    chk("s1_ready_cycles", 32'(hi), 32'd300);
    chk("s1_done", 32'(load_done), 32'd1);
    rd(9'd0);
    chk("s1_rd0", 32'(out), 32'h1FFF6A);
    chk("s1_rd0_vld", 32'(out_valid), 32'd1);
    rd(9'd299);
    chk("s1_rd299", 32'(out), 32'd149);
    idle();
`ifdef CHECKSUM_EN
    chk("s6_sum_ramp", checksum, 32'hFFFFFF6A);
    cycle(1'b0, 1, 0, '0, 0, '0);
    for (int i = 0; i < 300; i++) cycle(1'b0, 0, 1, 21'h1FFFFF, 0, '0);
    chk("s6_sum_ones", checksum, 32'hFFFFFED4);
    idle();
    chk("s6_sum_stable", checksum, 32'hFFFFFED4);
`endif

    // Scenario 2: wr_valid toggles on alternate cycles.
    cycle(1'b0, 1, 0, '0, 0, '0);
    n = 0;
    while (n < 300) begin
      d = 21'(n - 150);
      cycle(1'b0, 0, 1, d, 0, '0);
      n++;
      if (n < 300) begin
        chk("s2_not_done", 32'(load_done), 32'd0);
        cycle(1'b0, 0, 0, 21'h0ABCDE, 0, '0);
      end
    end
    chk("s2_done", 32'(load_done), 32'd1);
    rd(9'd0);
    chk("s2_rd0", 32'(out), 32'h1FFF6A);
    for (int i = 0; i < 20; i++) rd(9'($urandom_range(0, 299)));

    // Scenario 3: out-of-range reads.
    rd(9'd300);
    chk("s3_err300", 32'(addr_err), 32'd1);
    chk("s3_out300", 32'(out), 32'd0);
    rd(9'd511);
    chk("s3_err511", 32'(addr_err), 32'd1);
    idle();

    // Scenario 4: reset after 150 transfers.
    cycle(1'b0, 1, 0, '0, 0, '0);
    for (int i = 0; i < 150; i++) cycle(1'b0, 0, 1, 21'($urandom), 0, '0);
    cycle(1'b1, 0, 1, 21'($urandom), 0, '0);
    chk("s4_ready", 32'(wr_ready), 32'd0);
    chk("s4_done", 32'(load_done), 32'd0);
    for (int i = 0; i < 3; i++) rd(9'($urandom_range(0, 299)));
    cycle(1'b0, 1, 0, '0, 1, '0);
    n = 0;
    while (n < 300) begin
      if ($urandom_range(0, 2) != 0) begin
        cycle(1'b0, 0, 1, 21'($urandom), 1, 9'd5);
        n++;
      end else cycle(1'b0, 0, 0, 21'($urandom), 1, 9'd5);
    end
    for (int i = 0; i < 30; i++) rd(9'($urandom));

    // Scenario 5: a same-cycle load_start and read, then a restart mid-load.
    cycle(1'b0, 1, 0, '0, 1, 9'd7);
    chk("s5_no_vld", 32'(out_valid), 32'd0);
    chk("s5_done_drop", 32'(load_done), 32'd0);
    chk("s5_ready", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 100; i++) cycle(1'b0, 0, 1, 21'($urandom), 0, '0);
    cycle(1'b0, 1, 1, 21'h0DEAD, 0, '0);
    cycle(1'b0, 0, 1, 21'h12345, 0, '0);
    for (int i = 1; i < 300; i++) cycle(1'b0, 0, 1, 21'($urandom), 0, '0);
    rd(9'd0);
    chk("s5_rd0_restart", 32'(out), 32'h12345);
    for (int i = 0; i < 20; i++) rd(9'($urandom_range(0, 299)));
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
